// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the program counter, drives the synchronous-read
// instruction memory and holds the IF/ID pipeline register.
module fetch_stage #(
    parameter int                WIDTH    = 32,
    parameter logic [WIDTH-1:0]  RESET_PC = '0,
    parameter logic [WIDTH-1:0]  PC_INC   = WIDTH'(1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_branch,
    input  logic             redirect_mem,
    input  logic [WIDTH-1:0] alu_target,
    input  logic [WIDTH-1:0] mem_target,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_data,
    output logic [WIDTH-1:0] ifid_instr,
    output logic [WIDTH-1:0] ifid_pc,
    output logic             ifid_valid,
    output logic [31:0]      fetch_count
);

    logic [WIDTH-1:0] pc_p0;
    logic [WIDTH-1:0] pc_p1;
    logic             vld_p1;
    logic             redirect;
    logic [WIDTH-1:0] redirect_target;

    assign redirect        = redirect_mem | redirect_branch;
    assign redirect_target = redirect_mem ? mem_target : alu_target;

    // While stalled the memory re-reads the in-flight address so imem_data stays put.
    assign imem_addr = stall ? pc_p1 : pc_p0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_p0       <= RESET_PC;
            pc_p1       <= '0;
            vld_p1      <= 1'b0;
            ifid_instr  <= '0;
            ifid_pc     <= '0;
            ifid_valid  <= 1'b0;
            fetch_count <= '0;
        end else if (redirect) begin
            // Redirect squashes the in-flight word and overrides any stall.
            pc_p0      <= redirect_target;
            vld_p1     <= 1'b0;
            ifid_instr <= '0;
            ifid_pc    <= '0;
            ifid_valid <= 1'b0;
        end else if (!stall) begin
            // p0 -> p1: address issued to memory, word returns next cycle
            pc_p0  <= pc_p0 + PC_INC;
            pc_p1  <= pc_p0;
            vld_p1 <= 1'b1;
            // p1 -> IF/ID: bubbles are forced to all-zero so ID sees a clean nop
            ifid_instr <= vld_p1 ? imem_data : '0;
            ifid_pc    <= vld_p1 ? pc_p1 : '0;
            ifid_valid <= vld_p1;
            if (vld_p1) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed stimulus, a queue-based fetch model checked every
// cycle, and literal expectations at key points of the sequence.
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_branch = 1'b0;
    logic        redirect_mem = 1'b0;
    logic [31:0] alu_target = '0;
    logic [31:0] mem_target = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data = '0;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic        ifid_valid;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    fetch_stage #(.WIDTH(32), .RESET_PC(32'd0), .PC_INC(32'd1)) dut (
        .clock(clock), .reset(reset), .stall(stall),
        .redirect_branch(redirect_branch), .redirect_mem(redirect_mem),
        .alu_target(alu_target), .mem_target(mem_target),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid),
        .fetch_count(fetch_count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'h1000_0000 + a;
    endfunction

    // Synchronous-read instruction memory
    always @(posedge clock) imem_data <= memf(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pc plus a queue of addresses whose words are in flight.
    logic [31:0] m_pc = '0;
    logic [31:0] q[$];
    logic        m_valid = 1'b0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_ifpc = '0;
    logic [31:0] m_count = '0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_pc = 32'd0; q.delete();
            m_valid = 1'b0; m_instr = '0; m_ifpc = '0; m_count = '0;
        end else if (redirect_mem || redirect_branch) begin
            m_pc = redirect_mem ? mem_target : alu_target;
            q.delete();
            m_valid = 1'b0; m_instr = '0; m_ifpc = '0;
        end else if (!stall) begin
            if (q.size() > 0) begin
                m_ifpc  = q.pop_front();
                m_instr = memf(m_ifpc);
                m_valid = 1'b1;
                m_count = m_count + 32'd1;
            end else begin
                m_valid = 1'b0; m_instr = '0; m_ifpc = '0;
            end
            q.push_back(m_pc);
            m_pc = m_pc + 32'd1;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
            chk("ifid_instr", ifid_instr, m_instr);
            chk("ifid_pc", ifid_pc, m_ifpc);
            chk("fetch_count", fetch_count, m_count);
            if (!stall) chk("imem_addr", imem_addr, m_pc);
            else if (q.size() > 0) chk("imem_addr_stall", imem_addr, q[0]);
        end
    end

    task automatic tick(input logic s, input logic rb, input logic rm,
                        input logic [31:0] at, input logic [31:0] mt);
        stall = s; redirect_branch = rb; redirect_mem = rm;
        alu_target = at; mem_target = mt;
        @(posedge clock);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        #1 reset = 1'b1;
        #12 reset = 1'b0;
        chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'd0);
        chk_en = 1'b1;

        // Startup: valid rises on edge 2, four instructions after five edges
        idle(5);
        chk("run_pc", ifid_pc, 32'd3);
        chk("run_instr", ifid_instr, 32'h1000_0003);
        chk("run_count", fetch_count, 32'd4);

        // Stall three edges: memory re-reads address 4, IF/ID frozen
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
            chk("stall_addr", imem_addr, 32'd4);
            chk("stall_pc", ifid_pc, 32'd3);
        end
        idle(1);
        chk("unstall_pc", ifid_pc, 32'd4);
        chk("unstall_instr", ifid_instr, 32'h1000_0004);
        chk("unstall_count", fetch_count, 32'd5);
        idle(1);
        chk("pre_br_pc", ifid_pc, 32'd5);

        // Taken branch to 0x40: two bubbles, then target
        tick(1'b0, 1'b1, 1'b0, 32'h40, 32'd0);
        chk("br_bubble", {31'd0, ifid_valid}, 32'd0);
        chk("br_addr", imem_addr, 32'h40);
        idle(1);
        chk("br_bubble2", {31'd0, ifid_valid}, 32'd0);
        idle(1);
        chk("br_pc", ifid_pc, 32'h40);
        chk("br_instr", ifid_instr, 32'h1000_0040);
        chk("br_count", fetch_count, 32'd7);

        // jumpmem beats branch on the same edge
        tick(1'b0, 1'b1, 1'b1, 32'h40, 32'h80);
        chk("jm_addr", imem_addr, 32'h80);
        idle(2);
        chk("jm_pc", ifid_pc, 32'h80);
        chk("jm_count", fetch_count, 32'd8);

        // Redirect overrides stall
        tick(1'b1, 1'b1, 1'b0, 32'h20, 32'd0);
        chk("brst_bubble", {31'd0, ifid_valid}, 32'd0);
        idle(2);
        chk("brst_pc", ifid_pc, 32'h20);
        chk("brst_count", fetch_count, 32'd9);

        // PC wraps modulo 2^32
        tick(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd0);
        idle(2);
        chk("wrap_top", ifid_pc, 32'hFFFF_FFFF);
        chk("wrap_top_instr", ifid_instr, 32'h0FFF_FFFF);
        idle(1);
        chk("wrap_zero", ifid_pc, 32'd0);
        chk("wrap_count", fetch_count, 32'd11);
        idle(3);

        // Asynchronous reset mid-cycle clears state before the next edge
        #1 reset = 1'b1;
        #1;
        chk("arst_valid", {31'd0, ifid_valid}, 32'd0);
        chk("arst_count", fetch_count, 32'd0);
        chk("arst_pc", ifid_pc, 32'd0);
        chk("arst_addr", imem_addr, 32'd0);
        #2 reset = 1'b0;
        idle(1);
        chk("arst_e1_valid", {31'd0, ifid_valid}, 32'd0);
        idle(1);
        chk("arst_e2_valid", {31'd0, ifid_valid}, 32'd1);
        chk("arst_e2_pc", ifid_pc, 32'd0);
        chk("arst_e2_count", fetch_count, 32'd1);
        idle(2);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 3-stage pipeline (IF -> ID -> EX/WB). Owns the program counter and the IF/ID pipeline register.
- Drives the synchronous-read instruction memory.
- Takes the WB-stage redirects (taken branch/jump to ALU result; jumpmem to data-memory output) and the ID-stage stall.
- Presents {instruction, PC, valid} to the ID stage: register file, control, sign extender, branch-offset adder.

Parameters:
- WIDTH, 32, datapath/PC/instruction width
- RESET_PC, 0, PC value loaded on reset
- PC_INC, 1, PC increment per fetch (word-addressed instruction memory)

Ports:
- clock, input, 1, single system clock, rising edge
- reset, input, 1, asynchronous, active-high reset
- stall, input, 1, hold PC and IF/ID this edge (from ID hazard logic)
- redirect_branch, input, 1, taken branch/jump (OR of branch-Z, branch-N, jump) from WB
- redirect_mem, input, 1, jumpmem from WB; target comes from data memory
- alu_target, input, WIDTH, branch/jump target (EX/WB ALU result)
- mem_target, input, WIDTH, jumpmem target (EX/WB DMEM data)
- imem_addr, output, WIDTH, instruction memory address, sampled by memory on clock
- imem_data, input, WIDTH, instruction memory read data, valid 1 cycle after address sampled
- ifid_instr, output, WIDTH, instruction to ID stage
- ifid_pc, output, WIDTH, PC of ifid_instr
- ifid_valid, output, 1, ifid_instr is a real instruction (0 = bubble)
- fetch_count, output, 32, count of valid instructions delivered to ID

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high; all state clears immediately on assertion, independent of clock.
- Reset values:
  - pc = RESET_PC
  - f_valid = 0, f_pc = 0
  - ifid_instr = 0, ifid_pc = 0, ifid_valid = 0
  - fetch_count = 0
- Internal state:
  - pc: next address to fetch.
  - f_pc / f_valid: the address whose word is on imem_data, and whether that word is live.
- imem_addr = stall ? f_pc : pc (combinational). During a stall the memory re-reads the in-flight address, so imem_data stays stable.
- Priority at each rising edge: redirect_mem > redirect_branch > stall > normal advance.
- Normal advance (no redirect, stall=0):
  - pc <= pc + PC_INC, modulo 2^WIDTH.
  - f_pc <= pc; f_valid <= 1.
  - IF/ID <= {imem_data, f_pc, f_valid}.
  - fetch_count += 1 if f_valid.
- Stall (stall=1, no redirect): pc, f_pc, f_valid, IF/ID and fetch_count all hold.
- redirect_mem=1 (regardless of other inputs): pc <= mem_target; f_valid <= 0; IF/ID <= {0, 0, 0} (bubble); fetch_count holds.
- redirect_branch=1, redirect_mem=0: same as above with pc <= alu_target.
- A redirect overrides stall. The in-flight word is squashed and never reaches ID.
- Latency:
  - Address A held in pc at edge e: word sampled at e, latched into IF/ID at e+1 (if not stalled).
  - Redirect at edge e: first target instruction valid in IF/ID at e+2.
  - Throughput: 1 instruction/cycle.
- After reset deassertion:
  - First edge: fetches RESET_PC, ifid_valid stays 0.
  - Second edge: ifid_valid=1 with ifid_pc=RESET_PC.
- fetch_count wraps 0xFFFFFFFF -> 0.
- Bubbles (ifid_valid=0) carry instr=0. ID must gate control on ifid_valid.
- Squashing of instructions already in ID/EX is out of scope for this block.

Test Plan:
- Reset, RESET_PC=0, mem[i]=0x1000_0000+i, run 5 edges -> ifid_valid rises on edge 2; ifid_pc 0,1,2,3 with matching instr; fetch_count=4.
- stall=1 for 3 edges while ifid_pc=2 -> ifid_pc/instr/fetch_count frozen; imem_addr=f_pc=3; on release ifid_pc=3, instr=mem[3], no skip or duplicate.
- redirect_branch=1 with alu_target=0x40 while ifid_pc=5 -> next edge ifid_valid=0, pc=0x40; edge after ifid_valid=0; third edge ifid_pc=0x40, instr=mem[0x40]; mem[6], mem[7] never appear.
- redirect_branch=1 (alu_target=0x40) and redirect_mem=1 (mem_target=0x80) same edge -> pc=0x80; ifid_pc=0x80 two edges later.
- redirect_branch=1 while stall=1 -> redirect taken (pc=alu_target, bubble), stall ignored that edge.
- Assert reset asynchronously mid-cycle with ifid_valid=1, fetch_count=7 -> outputs clear before next edge; pc=RESET_PC; fetch restarts per reset latency.
